victim_cache: RTL and testbench

VICTIM_CACHE -- requirements
Module: victim_cache

---
 rtl/victim_cache.sv | 200 ++++++++++++++++++++
 tb/tb_victim_cache.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_cache.sv
// victim_cache -- small fully associative victim cache sitting beside an L1.
//
// Lines evicted from L1 are inserted with vc_write; an L1 miss probes with
// vc_read. Lookup is purely combinational against registered state, and a
// read hit hands the line back to L1 by invalidating the entry at the next
// rising edge, so a line lives in exactly one of L1 / victim cache. Lines
// displaced from a full cache are dropped (there is no write-back port).
//
// Parameters:
//   NUM_ENTRIES         number of lines, power of two in 2..16
//
// Ports:
//   clk                 clock, all state changes on the rising edge
//   rst                 asynchronous active-high reset (valid/dirty/pointer)
//   mem_address[31:0]   line address, tag = [31:5], [4:0] ignored
//   vc_write            insert/update the line at mem_address
//   vc_read             look up the line at mem_address
//   mem_wdata[255:0]    line data for vc_write
//   is_mem_wdata_dirty  dirty status of mem_wdata
//   rdata_exists        vc_read hit a valid entry (same cycle)
//   vc_vcmem_rdata256   hit data, all zeros when rdata_exists is low
//
// Build option:
//   VICTIM_CACHE_CLEAN_FIRST_EN  on a full-cache write miss, replace the
//   first clean line at or after the FIFO pointer instead of the line at
//   the pointer; falls back to plain FIFO when every line is dirty.

module victim_cache #(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         vc_write,
  input  logic         vc_read,
  input  logic [255:0] mem_wdata,
  input  logic         is_mem_wdata_dirty,
  output logic         rdata_exists,
  output logic [255:0] vc_vcmem_rdata256
);

  localparam int unsigned IDXW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  typedef logic [IDXW-1:0] idx_t;

  // Line state
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [NUM_ENTRIES-1:0] r_dirty;
  logic [26:0]            r_tag  [NUM_ENTRIES];
  logic [255:0]           r_data [NUM_ENTRIES];
  idx_t                   r_fifo_ptr;

  // Lookup
  logic [26:0]            w_tag;
  logic                   w_unused_offset;
  logic [NUM_ENTRIES-1:0] w_match;
  logic [NUM_ENTRIES-1:0] w_hit_vec;
  logic                   w_hit;
  idx_t                   w_hit_idx;
  logic                   w_rd_hit;

  // Write placement
  logic [NUM_ENTRIES-1:0] w_valid_post_rd;
  logic [NUM_ENTRIES-1:0] w_wr_hit_vec;
  logic                   w_wr_hit;
  idx_t                   w_wr_hit_idx;
  logic                   w_has_free;
  idx_t                   w_free_idx;
  idx_t                   w_victim_idx;
  idx_t                   w_wr_idx;

  assign w_tag           = mem_address[31:5];
  assign w_unused_offset = ^mem_address[4:0];

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_match[i] = (r_tag[i] == w_tag);
    end
  end

  assign w_hit_vec = w_match & r_valid;
  assign w_hit     = |w_hit_vec;

  // At most one entry can match, so OR-ing indices is a valid encoder.
  always_comb begin
    w_hit_idx = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (w_hit_vec[i]) begin
        w_hit_idx = w_hit_idx | idx_t'(i);
      end
    end
  end

  assign w_rd_hit          = vc_read & w_hit;
  assign rdata_exists      = w_rd_hit;
  assign vc_vcmem_rdata256 = w_rd_hit ? r_data[w_hit_idx] : '0;

  // The write sees the cache as it is after this edge's read invalidation:
  // a same-tag read+write becomes a write miss, and the freed slot counts
  // as free for placement.
  always_comb begin
    w_valid_post_rd = r_valid;
    if (w_rd_hit) begin
      w_valid_post_rd[w_hit_idx] = 1'b0;
    end
  end

  assign w_wr_hit_vec = w_match & w_valid_post_rd;
  assign w_wr_hit     = |w_wr_hit_vec;

  always_comb begin
    w_wr_hit_idx = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (w_wr_hit_vec[i]) begin
        w_wr_hit_idx = w_wr_hit_idx | idx_t'(i);
      end
    end
  end

  // Lowest-index free slot.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (!w_valid_post_rd[i] && !w_has_free) begin
        w_has_free = 1'b1;
        w_free_idx = idx_t'(i);
      end
    end
  end

`ifdef VICTIM_CACHE_CLEAN_FIRST_EN
  // Only consulted when every slot is valid, so the dirty bits alone
  // decide. Scan starts at the pointer and wraps; index arithmetic wraps
  // naturally because NUM_ENTRIES is a power of two.
  always_comb begin
    idx_t v_scan;
    logic v_found;
    v_found      = 1'b0;
    v_scan       = '0;
    w_victim_idx = r_fifo_ptr;
    for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
      v_scan = r_fifo_ptr + idx_t'(k);
      if (!v_found && !r_dirty[v_scan]) begin
        v_found      = 1'b1;
        w_victim_idx = v_scan;
      end
    end
  end
`else
  assign w_victim_idx = r_fifo_ptr;
`endif

  always_comb begin
    if (w_wr_hit) begin
      w_wr_idx = w_wr_hit_idx;
    end else if (w_has_free) begin
      w_wr_idx = w_free_idx;
    end else begin
      w_wr_idx = w_victim_idx;
    end
  end

  // Control state. Read invalidation is issued first so that a write to
  // the same slot on the same edge overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_dirty    <= '0;
      r_fifo_ptr <= '0;
    end else begin
      if (w_rd_hit) begin
        r_valid[w_hit_idx] <= 1'b0;
      end
      if (vc_write) begin
        if (w_wr_hit) begin
          r_dirty[w_wr_idx] <= r_dirty[w_wr_idx] | is_mem_wdata_dirty;
        end else begin
          r_valid[w_wr_idx] <= 1'b1;
          r_dirty[w_wr_idx] <= is_mem_wdata_dirty;
          if (!w_has_free) begin
            r_fifo_ptr <= w_victim_idx + idx_t'(1);
          end
        end
      end
    end
  end

  // Tag/data storage is unreset; anything written while rst is high is
  // unreachable because its valid bit is held clear.
  always_ff @(posedge clk) begin
    if (vc_write) begin
      r_data[w_wr_idx] <= mem_wdata;
      if (!w_wr_hit) begin
        r_tag[w_wr_idx] <= w_tag;
      end
    end
  end

endmodule

// File: tb/tb_victim_cache.sv
module tb_victim_cache;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         vc_write;
  logic         vc_read;
  logic [255:0] mem_wdata;
  logic         is_mem_wdata_dirty;
  logic         rdata_exists;
  logic [255:0] vc_vcmem_rdata256;

  victim_cache #(.NUM_ENTRIES(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_address       (mem_address),
    .vc_write          (vc_write),
    .vc_read           (vc_read),
    .mem_wdata         (mem_wdata),
    .is_mem_wdata_dirty(is_mem_wdata_dirty),
    .rdata_exists      (rdata_exists),
    .vc_vcmem_rdata256 (vc_vcmem_rdata256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a slot table with a round-robin pointer.
  bit           m_valid [N];
  bit           m_dirty [N];
  logic [26:0]  m_tag   [N];
  logic [255:0] m_data  [N];
  int           m_ptr;

  logic         obs_ex;
  logic [255:0] obs_d;

  function automatic int m_find(input logic [26:0] t);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_tag[i] == t) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic m_step(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [255:0] d, input bit dt);
    logic [26:0] t;
    int h;
    int slot;
    t = a[31:5];
    h = m_find(t);
    if (rd && h >= 0) m_valid[h] = 0;
    if (wr) begin
      h = m_find(t);
      if (h >= 0) begin
        m_data[h]  = d;
        m_dirty[h] = m_dirty[h] | dt;
      end else begin
        slot = -1;
        for (int i = 0; i < N; i++) begin
          if (!m_valid[i] && slot < 0) slot = i;
        end
        if (slot < 0) begin
          slot = m_ptr;
`ifdef VICTIM_CACHE_CLEAN_FIRST_EN
          for (int k = 0; k < N; k++) begin
            if (!m_dirty[(m_ptr + k) % N]) begin
              slot = (m_ptr + k) % N;
              break;
            end
          end
`endif
          m_ptr = (slot + 1) % N;
        end
        m_valid[slot] = 1;
        m_tag[slot]   = t;
        m_data[slot]  = d;
        m_dirty[slot] = dt;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // One clock: drive after the falling edge, check the combinational
  // lookup against the model, then advance the model at the rising edge.
  task automatic cyc(input bit wr, input bit rd, input logic [31:0] a,
                     input logic [255:0] d, input bit dt, input string nm);
    int h;
    logic         e_ex;
    logic [255:0] e_d;
    @(negedge clk);
    vc_write           = wr;
    vc_read            = rd;
    mem_address        = a;
    mem_wdata          = d;
    is_mem_wdata_dirty = dt;
    #1;
    obs_ex = rdata_exists;
    obs_d  = vc_vcmem_rdata256;
    h    = m_find(a[31:5]);
    e_ex = rd && (h >= 0);
    e_d  = e_ex ? m_data[h] : '0;
    chk({nm, "_ex"}, {255'd0, obs_ex}, {255'd0, e_ex});
    chk({nm, "_data"}, obs_d, e_d);
    @(posedge clk);
    m_step(wr, rd, a, d, dt);
  endtask

  // Async reset pulse between edges, with a write held across the edge
  // that rst covers.
  task automatic pulse_rst(input logic [31:0] a);
    @(negedge clk);
    vc_read            = 1'b1;
    vc_write           = 1'b1;
    mem_address        = a;
    mem_wdata          = '1;
    is_mem_wdata_dirty = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ex", {255'd0, rdata_exists}, 256'd0);
    chk("rst_async_data", vc_vcmem_rdata256, 256'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    vc_read  = 1'b0;
    vc_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] rd;
    logic [31:0]  ra;
    int           r;

    rst                = 1'b1;
    vc_write           = 1'b0;
    vc_read            = 1'b1;
    mem_address        = 32'h20;
    mem_wdata          = '0;
    is_mem_wdata_dirty = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("in_reset_ex", {255'd0, rdata_exists}, 256'd0);
    chk("in_reset_data", vc_vcmem_rdata256, 256'd0);
    @(negedge clk);
    rst     = 1'b0;
    vc_read = 1'b0;

    // Empty cache read
    cyc(0, 1, 32'h20, '0, 0, "empty_rd");
    chk("empty_rd_ex_c", {255'd0, obs_ex}, 256'd0);
    chk("empty_rd_data_c", obs_d, 256'd0);

    // Write then read: hit, then the entry has left
    cyc(1, 0, 32'h1, 256'h1, 0, "w1");
    cyc(0, 1, 32'h1, '0, 0, "r1");
    chk("r1_ex_c", {255'd0, obs_ex}, 256'd1);
    chk("r1_data_c", obs_d, 256'h1);
    cyc(0, 1, 32'h1, '0, 0, "r1_again");
    chk("r1_again_ex_c", {255'd0, obs_ex}, 256'd0);

    // Same tag via different offsets updates in place
    cyc(1, 0, 32'h40, 256'hA, 0, "w40");
    cyc(1, 0, 32'h5F, 256'hB, 0, "w5f");
    cyc(0, 1, 32'h40, '0, 0, "r40");
    chk("r40_data_c", obs_d, 256'hB);
    cyc(0, 1, 32'h5F, '0, 0, "r5f");
    chk("r5f_ex_c", {255'd0, obs_ex}, 256'd0);

    // Full cache replacement; only tag 3 is clean
    pulse_rst(32'h0);
    for (int t = 0; t < 8; t++) begin
      ra = t << 5;
      cyc(1, 0, ra, 256'(100 + t), (t != 3), "fill");
    end
    cyc(1, 0, 32'(8 << 5), 256'd108, 1, "w8");
`ifdef VICTIM_CACHE_CLEAN_FIRST_EN
    cyc(0, 1, 32'(3 << 5), '0, 0, "cf_t3");
    chk("cf_t3_ex_c", {255'd0, obs_ex}, 256'd0);
    cyc(0, 1, 32'(0 << 5), '0, 0, "cf_t0");
    chk("cf_t0_ex_c", {255'd0, obs_ex}, 256'd1);
    chk("cf_t0_data_c", obs_d, 256'd100);
`else
    cyc(0, 1, 32'(0 << 5), '0, 0, "ff_t0");
    chk("ff_t0_ex_c", {255'd0, obs_ex}, 256'd0);
    cyc(1, 0, 32'(9 << 5), 256'd109, 1, "w9");
    cyc(0, 1, 32'(1 << 5), '0, 0, "ff_t1");
    chk("ff_t1_ex_c", {255'd0, obs_ex}, 256'd0);
    for (int t = 2; t < 10; t++) begin
      ra = t << 5;
      cyc(0, 1, ra, '0, 0, "ff_hit");
      chk("ff_hit_data_c", obs_d, 256'(100 + t));
    end
`endif

    // Same-edge read and write of one tag
    pulse_rst(32'h0);
    cyc(1, 0, 32'h100, 256'h5, 0, "w100");
    cyc(1, 1, 32'h100, 256'h6, 0, "rw100");
    chk("rw100_ex_c", {255'd0, obs_ex}, 256'd1);
    chk("rw100_data_c", obs_d, 256'h5);
    cyc(0, 1, 32'h100, '0, 0, "r100");
    chk("r100_data_c", obs_d, 256'h6);
    cyc(1, 0, 32'h300, 256'h3, 1, "w300");
    cyc(1, 0, 32'h400, 256'h4, 0, "w400");
    pulse_rst(32'h200);
    cyc(0, 1, 32'h200, '0, 0, "post_rst_200");
    chk("post_rst_200_c", {255'd0, obs_ex}, 256'd0);
    cyc(0, 1, 32'h300, '0, 0, "post_rst_300");
    chk("post_rst_300_c", {255'd0, obs_ex}, 256'd0);
    cyc(0, 1, 32'h400, '0, 0, "post_rst_400");
    chk("post_rst_400_c", {255'd0, obs_ex}, 256'd0);

    // Random traffic over a tag pool larger than the cache
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 199);
      ra = ($urandom_range(0, 11) << 5) | ($urandom() & 32'h1F);
      if (r < 3) begin
        pulse_rst(ra);
      end else begin
        for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom();
        cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ra, rd,
            bit'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
